// File: rtl/shift_ctrl_pkg.sv
// Shared types and defaults for the shift-register load controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_HOLD  = 0;

endpackage

// File: rtl/shift_bit_counter.sv
// Saturating up-counter with synchronous clear, enable and terminal-count flag.
module shift_bit_counter #(
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned MAX_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal
);

    localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX_COUNT);

    assign terminal = (count == MaxVal);

    // Holds at MaxVal so a word can never wrap the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_load_controller.sv
// Parallel-to-serial sequencer feeding a serial-in shift register.
// Build option SHIFT_MSB_FIRST_EN selects MSB-first bit order (default LSB-first).
module shift_load_controller
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned HOLD  = DEFAULT_HOLD
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             Valid_In,
    output logic             Ready_Out,
    output logic             Ser_Out,
    output logic             Shift_En,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CntW    = $clog2(WIDTH);
    localparam int unsigned HoldMax = (HOLD > 0) ? HOLD - 1 : 0;
    localparam int unsigned HoldW   = (HoldMax > 0) ? $clog2(HoldMax + 1) : 1;

    state_e           state;
    logic [WIDTH-1:0] word;
    logic [CntW-1:0]  bit_cnt;
    logic             bit_last;
    logic [HoldW-1:0] hold_cnt;
    logic             hold_last;
    logic             accept;

    assign accept = (state == IDLE) && Valid_In;

    function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic [CntW-1:0] idx);
`ifdef SHIFT_MSB_FIRST_EN
        return w[CntW'(WIDTH - 1) - idx];
`else
        return w[idx];
`endif
    endfunction

    shift_bit_counter #(
        .CNT_W     (CntW),
        .MAX_COUNT (WIDTH - 1)
    ) u_bit_cnt (
        .clk      (Clock),
        .rst      (Reset),
        .clear    (accept),
        .enable   (state == SHIFT),
        .count    (bit_cnt),
        .terminal (bit_last)
    );

    shift_bit_counter #(
        .CNT_W     (HoldW),
        .MAX_COUNT (HoldMax)
    ) u_hold_cnt (
        .clk      (Clock),
        .rst      (Reset),
        .clear    (state == SHIFT),
        .enable   (state == GAP),
        .count    (hold_cnt),
        .terminal (hold_last)
    );

    // Outputs are computed one edge ahead so every port is a flop.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            word      <= '0;
            Ready_Out <= 1'b1;
            Ser_Out   <= 1'b0;
            Shift_En  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (Valid_In) begin
                        state     <= SHIFT;
                        word      <= Data_In;
                        Ready_Out <= 1'b0;
                        Busy      <= 1'b1;
                        Shift_En  <= 1'b1;
                        Ser_Out   <= pick_bit(Data_In, '0);
                        Done      <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_last) begin
                        Shift_En <= 1'b0;
                        Ser_Out  <= 1'b0;
                        Done     <= 1'b0;
                        if (HOLD > 0) begin
                            state <= GAP;
                        end else begin
                            state     <= IDLE;
                            Busy      <= 1'b0;
                            Ready_Out <= 1'b1;
                        end
                    end else begin
                        Ser_Out <= pick_bit(word, bit_cnt + CntW'(1));
                        Done    <= (bit_cnt == CntW'(WIDTH - 2));
                    end
                end
                GAP: begin
                    if (hold_last) begin
                        state     <= IDLE;
                        Busy      <= 1'b0;
                        Ready_Out <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    Ready_Out <= 1'b1;
                    Ser_Out   <= 1'b0;
                    Shift_En  <= 1'b0;
                    Busy      <= 1'b0;
                    Done      <= 1'b0;
                end
            endcase
        end
    end

    // The hold count must advance every gap cycle until it reaches its terminal value.
    hold_advances: assert property (@(posedge Clock) disable iff (Reset)
        (state == GAP && !hold_last) |=> (hold_cnt != '0));

endmodule

// File: tb/tb_shift_load_controller.sv
// Bench for shift_load_controller: HOLD=0 and HOLD=3 instances against a timeline model.
module tb_shift_load_controller;

    localparam int W  = 4;
    localparam int H1 = 3;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [3:0] data0, data1;
    logic       v0, v1;
    logic       r0, s0, e0, b0, d0;
    logic       r1, s1, e1, b1, d1;
    logic [4:0] vec0, vec1;

    int checks = 0;
    int passed = 0;

    // Model: md = cycles since handshake (0 = idle), mw = captured word.
    int         md[2];
    logic [3:0] mw[2];
    logic       hs[2];

    always #5 Clock = ~Clock;

    assign vec0 = {r0, s0, e0, b0, d0};
    assign vec1 = {r1, s1, e1, b1, d1};

    shift_load_controller #(.WIDTH(W), .HOLD(0)) u_h0 (
        .Clock(Clock), .Reset(Reset), .Data_In(data0), .Valid_In(v0), .Ready_Out(r0),
        .Ser_Out(s0), .Shift_En(e0), .Busy(b0), .Done(d0)
    );

    shift_load_controller #(.WIDTH(W), .HOLD(H1)) u_h3 (
        .Clock(Clock), .Reset(Reset), .Data_In(data1), .Valid_In(v1), .Ready_Out(r1),
        .Ser_Out(s1), .Shift_En(e1), .Busy(b1), .Done(d1)
    );

    function automatic int hold_of(input int i);
        return (i == 0) ? 0 : H1;
    endfunction

    // n-th bit sent on the wire for word w.
    function automatic logic ref_bit(input logic [3:0] w, input int n);
        logic [3:0] t;
`ifdef SHIFT_MSB_FIRST_EN
        t = w << n;
        return t[3];
`else
        t = w >> n;
        return t[0];
`endif
    endfunction

    // Expected {Ready_Out, Ser_Out, Shift_En, Busy, Done}.
    function automatic logic [4:0] exp_vec(input int i);
        int d;
        d = md[i];
        if (d == 0) return 5'b10000;
        if (d <= W) return {1'b0, ref_bit(mw[i], d - 1), 1'b1, 1'b1, (d == W)};
        return 5'b00010;
    endfunction

    task automatic model_edge();
        logic       vv;
        logic [3:0] dd;
        for (int i = 0; i < 2; i++) begin
            vv = (i == 0) ? v0 : v1;
            dd = (i == 0) ? data0 : data1;
            hs[i] = 1'b0;
            if (Reset) begin
                md[i] = 0;
            end else if (md[i] == 0) begin
                if (vv) begin
                    mw[i] = dd;
                    md[i] = 1;
                    hs[i] = 1'b1;
                end
            end else begin
                md[i]++;
                if (md[i] > W + hold_of(i)) md[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        v0 = 1'b0; v1 = 1'b0; data0 = '0; data1 = '0;
        md[0] = 0; md[1] = 0;
        #3;
        checks++;
        if (vec0 !== 5'b10000) $display("FAIL reset_h0 got=%b exp=10000", vec0);
        else passed++;
        checks++;
        if (vec1 !== 5'b10000) $display("FAIL reset_h3 got=%b exp=10000", vec1);
        else passed++;
        tick();
        checks++;
        if (vec0 !== 5'b10000) $display("FAIL reset_held got=%b exp=10000", vec0);
        else passed++;
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_single_word();
        logic [3:0] got_seq = '0;
        logic [3:0] sreg = '0;
        logic [3:0] exp_seq;
        int n_shift = 0;
        int n_done = 0;
        int done_at = -1;
`ifdef SHIFT_MSB_FIRST_EN
        exp_seq = 4'b1011;
`else
        exp_seq = 4'b1101;
`endif
        data0 = 4'b1011; v0 = 1'b1;
        tick();
        v0 = 1'b0; data0 = 4'($urandom);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (vec0 !== exp_vec(0)) $display("FAIL single_word c=%0d got=%b exp=%b", c, vec0,
                                              exp_vec(0));
            else passed++;
            if (e0) begin
                n_shift++;
                got_seq = {got_seq[2:0], s0};
`ifdef SHIFT_MSB_FIRST_EN
                sreg = {sreg[2:0], s0};
`else
                sreg = {s0, sreg[3:1]};
`endif
            end
            if (d0) begin
                n_done++;
                done_at = n_shift;
            end
            tick();
        end
        checks++;
        if (got_seq !== exp_seq) $display("FAIL ser_order got=%b exp=%b", got_seq, exp_seq);
        else passed++;
        checks++;
        if (n_shift != 4 || n_done != 1 || done_at != 4)
            $display("FAIL shift_done shifts=%0d dones=%0d done_at=%0d exp=4/1/4", n_shift,
                     n_done, done_at);
        else passed++;
        checks++;
        if (sreg !== 4'b1011) $display("FAIL sreg_word got=%b exp=1011", sreg);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int hs_n = 0;
        int hs_c[2] = '{-100, -100};
        int low = 0;
        data0 = 4'hA; v0 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (r0 && v0 && hs_n < 2) begin
                hs_c[hs_n] = c;
                hs_n++;
            end
            tick();
            if (hs[0]) begin
                if (data0 == 4'hA) data0 = 4'h5;
                else v0 = 1'b0;
            end
            if (hs_n == 1 && !r0) low++;
            checks++;
            if (vec0 !== exp_vec(0)) $display("FAIL back_to_back c=%0d got=%b exp=%b", c, vec0,
                                              exp_vec(0));
            else passed++;
        end
        v0 = 1'b0;
        checks++;
        if (hs_c[1] - hs_c[0] != 5) $display("FAIL b2b_spacing got=%0d exp=5", hs_c[1] - hs_c[0]);
        else passed++;
        checks++;
        if (low != 4) $display("FAIL b2b_ready_low got=%0d exp=4", low);
        else passed++;
    endtask

    task automatic test_hold();
        int busy = 0;
        int ready_at = -1;
        data1 = 4'($urandom); v1 = 1'b1;
        tick();
        v1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            checks++;
            if (vec1 !== exp_vec(1)) $display("FAIL hold c=%0d got=%b exp=%b", c, vec1,
                                              exp_vec(1));
            else passed++;
            if (b1) busy++;
            if (r1 && ready_at < 0) ready_at = c;
            tick();
        end
        checks++;
        if (busy != 7) $display("FAIL hold_busy got=%0d exp=7", busy);
        else passed++;
        checks++;
        if (ready_at != 8) $display("FAIL hold_ready got=%0d exp=8", ready_at);
        else passed++;
    endtask

    task automatic test_ignore();
        int busy = 0;
        int dones = 0;
        data0 = 4'($urandom_range(0, 14)); v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (vec0 !== exp_vec(0)) $display("FAIL ignore c=%0d got=%b exp=%b", c, vec0,
                                              exp_vec(0));
            else passed++;
            if (b0) busy++;
            if (d0) dones++;
            if (c == 1) begin
                v0 = 1'b1; data0 = 4'hF;
            end
            if (c == 2) v0 = 1'b0;
            tick();
        end
        checks++;
        if (busy != 4 || dones != 1) $display("FAIL ignore_extra busy=%0d dones=%0d exp=4/1", busy,
                                              dones);
        else passed++;
    endtask

    task automatic test_reset_mid();
        data0 = 4'($urandom); v0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        checks++;
        if (vec0 !== exp_vec(0)) $display("FAIL mid_second_bit got=%b exp=%b", vec0, exp_vec(0));
        else passed++;
        #2 Reset = 1'b1;
        md[0] = 0; md[1] = 0;
        #1;
        checks++;
        if (vec0 !== 5'b10000) $display("FAIL mid_async got=%b exp=10000", vec0);
        else passed++;
        tick();
        checks++;
        if (vec0 !== 5'b10000) $display("FAIL mid_no_done got=%b exp=10000", vec0);
        else passed++;
        Reset = 1'b0;
        #1;
        checks++;
        if (r0 !== 1'b1) $display("FAIL mid_release_ready got=%b exp=1", r0);
        else passed++;
        data0 = 4'($urandom); v0 = 1'b1;
        tick();
        v0 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (vec0 !== exp_vec(0)) $display("FAIL after_reset c=%0d got=%b exp=%b", c, vec0,
                                              exp_vec(0));
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            if (!v0 && $urandom_range(0, 1) == 1) begin
                v0 = 1'b1; data0 = 4'($urandom);
            end
            if (!v1 && $urandom_range(0, 1) == 1) begin
                v1 = 1'b1; data1 = 4'($urandom);
            end
            tick();
            if (hs[0]) v0 = 1'b0;
            if (hs[1]) v1 = 1'b0;
            checks++;
            if (vec0 !== exp_vec(0)) $display("FAIL random_h0 n=%0d got=%b exp=%b", n, vec0,
                                              exp_vec(0));
            else passed++;
            checks++;
            if (vec1 !== exp_vec(1)) $display("FAIL random_h3 n=%0d got=%b exp=%b", n, vec1,
                                              exp_vec(1));
            else passed++;
        end
        v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_hold();
        test_ignore();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/shift_load_controller.md
# shift_load_controller

Sequencer that feeds the team's 4-stage serial-in shift register (`registradorNaoBloqueante`) from a parallel source. It accepts a WIDTH-bit word over a valid/ready handshake and presents it bit by bit on `Ser_Out` with a `Shift_En` strobe. It then signals completion with a one-cycle `Done` pulse. It sits between a parallel producer and the shift register's `In` pin, and gates the register's clock enable.

## Interface
- `WIDTH`, default 4: word length and number of shift cycles per word; must be ≥ 2.
- `HOLD`, default 0: idle cycles inserted after each word before `Ready_Out` reasserts; range 0–15.

Ports:
- `Clock` (in, 1): single clock; all state updates on the rising edge.
- `Reset` (in, 1): asynchronous, active-high. Forces every register to its reset value immediately.
- `Data_In` (in, WIDTH): parallel word; sampled only on handshake.
- `Valid_In` (in, 1): producer has a word on `Data_In`.
- `Ready_Out` (out, 1): controller can accept a word.
- `Ser_Out` (out, 1): serial bit; connects to the shift register `In`.
- `Shift_En` (out, 1): high on each cycle where `Ser_Out` carries a valid bit that the register must shift in.
- `Busy` (out, 1): high in SHIFT and GAP.
- `Done` (out, 1): one-cycle pulse, concurrent with the last `Shift_En`.

## Operation
- State machine with three states: IDLE, SHIFT, GAP. Reset state is IDLE.
- Reset values: `Ready_Out`=1, `Ser_Out`=0, `Shift_En`=0, `Busy`=0, `Done`=0, bit counter=0, word register=0.
- IDLE: `Ready_Out`=1. On an edge with `Valid_In`=1, the controller captures `Data_In` into the word register, clears the counter, and moves to SHIFT.
- SHIFT:
  - `Shift_En`=1, `Busy`=1, `Ready_Out`=0.
  - `Ser_Out` = selected bit of the word register.
  - The counter increments each cycle.
  - When the counter = WIDTH-1, `Done`=1 for that cycle. The next state is GAP if HOLD>0, otherwise IDLE.
- GAP: `Busy`=1, `Shift_En`=0, `Ser_Out`=0. Lasts exactly HOLD cycles, then goes to IDLE.
- All outputs are registered; none depend combinationally on `Valid_In` or `Data_In`.
- `Valid_In` while `Ready_Out`=0 is ignored. The producer must hold `Valid_In` and `Data_In` until the handshake occurs.
- Counter width is $clog2(WIDTH). The counter saturates at WIDTH-1 and never wraps during a word.
- Reset asserted mid-word aborts the transfer immediately. The partial word is discarded and there is no `Done`. The downstream register content is undefined until the next full word.

## Timing
- Handshake at edge k: first `Shift_En` in cycle k+1, last in cycle k+WIDTH; `Done` in cycle k+WIDTH.
- `Ready_Out` returns high in cycle k+WIDTH+1+HOLD.
- Throughput: one word per WIDTH+1+HOLD cycles. With WIDTH=4 and HOLD=0, that is one word per 5 cycles.
- If `Valid_In` stays high, the next word is accepted on the first edge where `Ready_Out`=1. No cycle is lost beyond the mandatory one IDLE cycle.
- Reset release: `Ready_Out` is already 1, so a handshake is possible on the first edge after deassertion.

## Configuration
- `SHIFT_MSB_FIRST_EN` defined: bit order is `Data_In`[WIDTH-1] first, down to [0].
- `SHIFT_MSB_FIRST_EN` undefined (default): LSB first, [0] up to [WIDTH-1].
- Timing, handshake and `Done` behaviour are identical in both builds.

## Structure
- Shared package `shift_ctrl_pkg`:
  - state enum constants IDLE=2'd0, SHIFT=2'd1, GAP=2'd2;
  - default WIDTH/HOLD constants.
- One natural sub-module, `shift_bit_counter`, a parameterised up-counter. It has clear, enable and terminal-count output, and serves both the SHIFT bit count and the GAP hold count. The FSM and bit select stay in the top module.

## Test plan
- Reset, then `Data_In`=4'b1011 with `Valid_In`=1 for one edge (LSB-first build) → `Ser_Out` = 1,1,0,1 over 4 `Shift_En` cycles; `Done` on the 4th; attached shift register holds the word afterwards.
- Same word with `SHIFT_MSB_FIRST_EN` defined → `Ser_Out` = 1,0,1,1.
- `Valid_In` held high with words 4'hA then 4'h5, HOLD=0 → second handshake exactly 5 cycles after the first; `Ready_Out` low for 4 cycles between them.
- HOLD=3 → `Busy` high for 7 cycles per word; `Ready_Out` reasserts 8 cycles after the handshake.
- `Valid_In` pulsed with 4'hF during SHIFT → ignored; the in-flight word completes unchanged and no second transfer starts.
- `Reset` asserted at the 2nd shift bit → all outputs at reset values within the same cycle with no clock edge needed; no `Done`; `Ready_Out`=1 after release.
